// File: rtl/instr_dcd_burst_pkg.sv
// Shared definitions for the SPI instruction decoder: instruction byte layout,
// default address width and FSM state encodings.
package instr_dcd_burst_pkg;

  localparam int ADDR_W_DEF = 6;

  // Instruction byte layout; the address occupies the low ADDR_W bits.
  localparam int RW_BIT    = 7;
  localparam int BURST_BIT = 6;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_FETCH   = 2'd1;
  localparam state_t ST_DATA    = 2'd2;
  localparam state_t ST_DISCARD = 2'd3;

endpackage

// File: rtl/instr_dcd_burst.sv
// SPI-side instruction decoder with burst auto-increment, read prefetch from a
// 1-cycle registered register file, and overrun reporting past MAX_BURST bytes.
module instr_dcd_burst
  import instr_dcd_burst_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_read,
  output logic [7:0]        data_write,
  output logic              busy,
  output logic              overrun
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t           state;
  logic             rw_q;
  logic             burst_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  // inc_pend: address bump owed one cycle after a data byte.
  // load_pend: register file data arrives this cycle and must be captured.
  logic             inc_pend;
  logic             load_pend;

  assign count_nxt = count + CNT_W'(1);
  assign busy      = (state != ST_IDLE);

  // NOTE: the reset is asynchronous and active-low, so it sits in the sensitivity
  // list; every state bit returns to its reset value the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rw_q       <= 1'b0;
      burst_q    <= 1'b0;
      count      <= '0;
      inc_pend   <= 1'b0;
      load_pend  <= 1'b0;
      addr       <= '0;
      data_out   <= 8'h00;
      data_write <= 8'h00;
      read       <= 1'b0;
      write      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees the
      // pre-edge values and the strobes default low before any branch raises them.
      read    <= 1'b0;
      write   <= 1'b0;
      overrun <= 1'b0;

      if (cs_n) begin
        // Chip select dominates: frame aborted, pending work and any byte dropped.
        state     <= ST_IDLE;
        inc_pend  <= 1'b0;
        load_pend <= 1'b0;
        data_out  <= 8'h00;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_sync) begin
              rw_q      <= data_in[RW_BIT];
              burst_q   <= data_in[BURST_BIT];
              addr      <= data_in[ADDR_W-1:0];
              count     <= '0;
              inc_pend  <= 1'b0;
              load_pend <= 1'b0;
              if (data_in[RW_BIT]) begin
                data_out <= 8'h00;
                state    <= ST_DATA;
              end else begin
                read  <= 1'b1;
                state <= ST_FETCH;
              end
            end
          end

          ST_FETCH: begin
            // The read strobe is visible this cycle; its data lands next cycle.
            load_pend <= 1'b1;
            state     <= ST_DATA;
            if (byte_sync) begin
              overrun <= 1'b1;
            end
          end

          ST_DATA: begin
            if (load_pend) begin
              data_out  <= data_read;
              load_pend <= 1'b0;
            end else if (inc_pend) begin
              addr     <= addr + ADDR_W'(1);
              inc_pend <= 1'b0;
              if (!rw_q) begin
                read  <= 1'b1;
                state <= ST_FETCH;
              end
            end else if (byte_sync) begin
              count <= count_nxt;
              if (rw_q) begin
                write      <= 1'b1;
                data_write <= data_in;
              end
              if (!burst_q) begin
                state    <= ST_IDLE;
                data_out <= 8'h00;
              end else if (count_nxt == MAX_CNT) begin
                state    <= ST_DISCARD;
                data_out <= 8'h00;
              end else begin
                inc_pend <= 1'b1;
              end
            end
          end

          ST_DISCARD: begin
            if (byte_sync) begin
              overrun <= 1'b1;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_dcd_burst.sv
// Scoreboard bench for instr_dcd_burst: frames are expanded by a frame-level model
// into expected strobes and data_out values, which a monitor checks as they appear.
module tb_instr_dcd_burst;
  import instr_dcd_burst_pkg::*;

  localparam int AW = 6;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs_n;
  logic          byte_sync;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [7:0]    data_read;
  logic [7:0]    data_write;
  logic          busy;
  logic          overrun;

  instr_dcd_burst #(.ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_read  (data_read),
    .data_write (data_write),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {EV_RD = 3'b100, EV_WR = 3'b010, EV_OVR = 3'b001} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [AW-1:0] ev_addr;
    logic [7:0]    ev_data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] dout_q[$];
  logic [7:0] fix_q[$];
  logic [7:0] mdl [64];
  ev_t        mon_e;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Registered register file: read data valid the cycle after read.
  logic [7:0] rf_mem [64];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) rf_mem[i] <= init_val(i);
      data_read <= 8'h00;
    end else begin
      if (read)  data_read <= rf_mem[addr];
      if (write) rf_mem[addr] <= data_write;
    end
  end

  // Monitor: every strobe and every byte slot is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (read || write || overrun) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: read=%0b write=%0b overrun=%0b addr=0x%0h, expected none",
                   read, write, overrun, addr);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", {29'd0, read, write, overrun}, {29'd0, mon_e.kind});
          if (mon_e.kind != EV_OVR) check("strobe_addr", 32'(addr), 32'(mon_e.ev_addr));
          if (mon_e.kind == EV_WR) check("write_data", 32'(data_write), 32'(mon_e.ev_data));
        end
      end
      if (byte_sync && !cs_n) begin
        if (dout_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte_slot: data_out=0x%0h, expected no byte", data_out);
        end else begin
          check("data_out", 32'(data_out), 32'(dout_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_sync = 1'b1;
    data_in   = b;
    tick(1);
    byte_sync = 1'b0;
    tick(9);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = init_val(i);
  endtask

  // Frame-level model: a burst touches base+i for i < MB, bytes beyond MB overrun;
  // a read frame prefetches the next address after each data byte that is not the last allowed.
  task automatic run_frame(input logic [7:0] instr, input int n, input bit end_frame);
    logic          rw;
    logic          burst;
    logic [AW-1:0] base;
    logic [AW-1:0] ea;
    logic [7:0]    d;
    rw    = instr[RW_BIT];
    burst = instr[BURST_BIT];
    base  = instr[AW-1:0];
    cs_n  = 1'b0;
    tick(2);
    dout_q.push_back(8'h00);
    if (!rw) exp_q.push_back('{EV_RD, base, 8'h00});
    send_byte(instr);
    for (int i = 0; i < n; i++) begin
      d = (i < fix_q.size()) ? fix_q[i] : 8'($urandom);
      if (burst && i >= MB) begin
        exp_q.push_back('{EV_OVR, '0, 8'h00});
        dout_q.push_back(8'h00);
      end else begin
        ea = base + AW'(i);
        if (rw) begin
          dout_q.push_back(8'h00);
          exp_q.push_back('{EV_WR, ea, d});
          mdl[ea] = d;
        end else begin
          dout_q.push_back(mdl[ea]);
          if (burst && (i + 1 < MB)) exp_q.push_back('{EV_RD, ea + AW'(1), 8'h00});
        end
      end
      send_byte(d);
    end
    fix_q.delete();
    check("busy_in_frame", 32'(busy), 32'(burst));
    if (end_frame) begin
      cs_n = 1'b1;
      tick(1);
      check("busy_after_cs_n", 32'(busy), 32'd0);
      check("data_out_after_cs_n", 32'(data_out), 32'd0);
      tick(3);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_read"}, 32'(read), 32'd0);
    check({tag, "_write"}, 32'(write), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_data_write"}, 32'(data_write), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] instr;
    rst_n     = 1'b0;
    cs_n      = 1'b1;
    byte_sync = 1'b0;
    data_in   = 8'h00;
    model_reset();
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    fix_q = '{8'hA5};
    run_frame(8'h85, 1, 1'b1);
    fix_q = '{8'h3C};
    run_frame(8'h8A, 1, 1'b1);
    run_frame(8'h0A, 1, 1'b1);
    fix_q = '{8'h11, 8'h22, 8'h33};
    run_frame(8'hC2, 3, 1'b1);
    run_frame(8'h7E, 6, 1'b1);
    fix_q = '{8'h55};
    run_frame(8'hC0, 1, 1'b1);
    fix_q = '{8'h99};
    run_frame(8'h81, 1, 1'b1);

    // Reset in the middle of a burst write, cs_n left low across it.
    run_frame(8'hC8, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run_frame(8'h83, 1, 1'b1);
    run_frame(8'h03, 1, 1'b1);

    for (int k = 0; k < 30; k++) begin
      instr = 8'($urandom);
      run_frame(instr, instr[BURST_BIT] ? int'($urandom_range(1, MB + 2)) : 1, 1'b1);
    end

    tick(5);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("dout_queue_empty", 32'(dout_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
